// File: rtl/udma_rx_lin_arbiter_if.sv
// rtl/udma_rx_lin_arbiter_if.sv - RX linear channel collection bus (channels in, one tagged stream out)
interface udma_rx_lin_arbiter_if #(
    parameter int N_CH   = 6,
    parameter int DATA_W = 32,
    parameter int ID_W   = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic [N_CH-1:0]        ch_en_i;
    logic [N_CH-1:0]        ch_valid_i;
    logic [N_CH*DATA_W-1:0] ch_data_i;
    logic [N_CH*2-1:0]      ch_size_i;
    logic [N_CH-1:0]        ch_ready_o;
    logic                   out_valid_o;
    logic [DATA_W-1:0]      out_data_o;
    logic [1:0]             out_size_o;
    logic [ID_W-1:0]        out_id_o;
    logic                   out_ready_i;

    modport slave (
        input  ch_en_i, ch_valid_i, ch_data_i, ch_size_i, out_ready_i,
        output ch_ready_o, out_valid_o, out_data_o, out_size_o, out_id_o
    );

    modport master (
        output ch_en_i, ch_valid_i, ch_data_i, ch_size_i, out_ready_i,
        input  ch_ready_o, out_valid_o, out_data_o, out_size_o, out_id_o
    );
endinterface

// File: rtl/udma_rx_lin_arbiter.sv
// rtl/udma_rx_lin_arbiter.sv - round-robin RX channel arbiter; UDMA_RX_ARB_SKID_EN selects a 2-entry output FIFO
module udma_rx_lin_arbiter #(
    parameter int N_CH   = 6,
    parameter int DATA_W = 32,
    parameter int ID_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    udma_rx_lin_arbiter_if.slave  bus
);

    logic [N_CH-1:0]   req;
    logic [N_CH-1:0]   ch_ready;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   grant_id;
    logic              found;
    logic              can_accept;
    logic              xfer;
    logic [DATA_W-1:0] grant_data;
    logic [1:0]        grant_size;
    int                idx;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_size;
    logic [ID_W-1:0]   out_id;

    // Search starts just after the last served channel so every requester waits at most N_CH-1 beats.
    always_comb begin
        req      = bus.ch_valid_i & bus.ch_en_i;
        found    = 1'b0;
        grant_id = '0;
        idx      = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(ptr) + k) % N_CH;
            if (!found && req[idx]) begin
                found    = 1'b1;
                grant_id = ID_W'(idx);
            end
        end
    end

    assign xfer       = found && can_accept && !rst_i;
    assign grant_data = bus.ch_data_i[int'(grant_id)*DATA_W +: DATA_W];
    assign grant_size = bus.ch_size_i[int'(grant_id)*2 +: 2];

    always_comb begin
        ch_ready = '0;
        if (xfer) begin
            ch_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr <= ID_W'(N_CH - 1);
        end else if (xfer) begin
            ptr <= grant_id;
        end
    end

`ifdef UDMA_RX_ARB_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [1:0]        skid_size;
    logic [ID_W-1:0]   skid_id;
    logic              pop;

    // Head register plus one skid slot; the skid slot is only occupied while the head is.
    assign can_accept = !skid_valid;
    assign pop        = out_valid && bus.out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_size   <= '0;
            out_id     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_size  <= '0;
            skid_id    <= '0;
        end else if (pop && skid_valid) begin
            out_data   <= skid_data;
            out_size   <= skid_size;
            out_id     <= skid_id;
            skid_valid <= 1'b0;
        end else if (xfer && out_valid && !pop) begin
            skid_valid <= 1'b1;
            skid_data  <= grant_data;
            skid_size  <= grant_size;
            skid_id    <= grant_id;
        end else if (xfer) begin
            out_valid  <= 1'b1;
            out_data   <= grant_data;
            out_size   <= grant_size;
            out_id     <= grant_id;
        end else if (pop) begin
            out_valid  <= 1'b0;
        end
    end
`else
    assign can_accept = !out_valid || bus.out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_size  <= '0;
            out_id    <= '0;
        end else if (can_accept) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= grant_data;
                out_size <= grant_size;
                out_id   <= grant_id;
            end
        end
    end
`endif

    assign bus.ch_ready_o  = ch_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = out_data;
    assign bus.out_size_o  = out_size;
    assign bus.out_id_o    = out_id;

endmodule

// File: doc/udma_rx_lin_arbiter.md
# udma_rx_lin_arbiter

Round-robin arbiter that collects receive data from all uDMA linear RX channels (UART, QSPIM, I2C, SDIO, CPI, HyperBus) and forwards one beat per cycle, tagged with its channel ID, toward the L2 write path. It is the receive-side counterpart of the TX channel distribution: peripherals push beats in, the core drains a single stream out. Channel index `i` on the input vector is the RX linear channel ID from the uDMA configuration package.

## Interface
Parameters:
- `N_CH`, 6, number of RX linear channels (must be ≥ 2).
- `DATA_W`, 32, beat data width.
- `ID_W`, `$clog2(N_CH)`, channel-ID width (derived; minimum 1).

Ports:
- `clk_i`  in  1  system clock; the block uses this clock only.
- `rst_i`  in  1  asynchronous, active-high reset.
- `ch_en_i`  in  N_CH  per-channel enable; a disabled channel is never granted.
- `ch_valid_i`  in  N_CH  per-channel beat valid.
- `ch_data_i`  in  N_CH×DATA_W  per-channel beat data.
- `ch_size_i`  in  N_CH×2  per-channel data size: 0 = byte, 1 = half-word, 2 = word. Value 3 is reserved and is passed through unchanged.
- `ch_ready_o`  out  N_CH  per-channel ready; one-hot or zero.
- `out_valid_o`  out  1  output beat valid.
- `out_data_o`  out  DATA_W  output data.
- `out_size_o`  out  2  output data size.
- `out_id_o`  out  ID_W  source channel ID of the output beat.
- `out_ready_i`  in  1  downstream ready.

## Operation
- **Handshake.** Standard valid/ready on both sides. A beat transfers when valid and ready are both high on a rising edge of `clk_i`. Once `ch_valid_i[i]` is raised, its data and size stay stable until the transfer.
- **Request set.** `req = ch_valid_i & ch_en_i`.
- **Grant.** The grant is combinational. Search `req` starting at `ptr+1`, wrapping from N_CH−1 to 0, and take the first set bit. The grant is issued only when the output stage can accept a beat.
- **Ready.** `ch_ready_o` = one-hot of the grant when the output stage can accept a beat, otherwise 0. No ready is ever raised for a channel whose `req` bit is 0.
- **Pointer update.** `ptr` updates to the granted index only on a transfer. With no transfer, `ptr` holds.
- **Output stage.** The accepted beat is stored as {data, size, id = granted index}.
- **Fairness.** With all N_CH channels requesting continuously, each channel is served exactly once in every N_CH transfers.
- **Disable while waiting.** If `ch_en_i[i]` drops while channel i is waiting, it is simply skipped; no beat is lost, because that channel's ready stays low.
- **Reset.**
  - `ptr` = N_CH−1, so channel 0 has first priority after reset.
  - `out_valid_o` = 0, `out_data_o` = 0, `out_size_o` = 0, `out_id_o` = 0.
  - `ch_ready_o` = 0 while `rst_i` is high.
- **Reset mid-operation.** Asserting `rst_i` drops any buffered beat immediately, with no drain.

## Timing
- Latency is 1 cycle: a beat accepted at edge k appears on `out_valid_o` after edge k.
- Throughput is one beat per cycle when `out_ready_i` is held high.
- **Default output stage** (single register):
  - Can accept when `!out_valid_o || out_ready_i`.
  - `ch_ready_o` therefore has a combinational path from `out_ready_i`.
  - Simultaneous drain and fill in the same cycle is allowed; the register is reloaded.
- The output holds `out_*` stable while `out_valid_o && !out_ready_i`.

## Configuration
- **Macro:** `UDMA_RX_ARB_SKID_EN`.
- **Defined:** the output stage is a 2-entry FIFO.
  - Can accept when fewer than 2 entries are held.
  - No combinational path from `out_ready_i` to `ch_ready_o`.
  - Full throughput is sustained.
  - Outputs come from the head entry.
  - When empty, `out_valid_o` = 0 and `out_*` hold the last value (0 after reset).
- **Undefined:** single register stage as described under Timing.
- Latency is 1 cycle in both builds. Arbitration order is identical in both builds.

## Test plan
- **Single channel.** After reset, channel 2 alone is valid with data 0xA5A5_0001, size 2, and `out_ready_i` = 1. Required: `ch_ready_o` = 0b000100. One cycle later `out_valid_o` = 1, `out_data_o` = 0xA5A5_0001, `out_id_o` = 2, `out_size_o` = 2.
- **All channels, continuous.** All 6 channels valid and enabled, `out_ready_i` = 1. Required: output IDs 0,1,2,3,4,5,0,1,… with exactly one beat per cycle.
- **Backpressure.** Channels 0 and 3 valid, `out_ready_i` held 0 for 5 cycles. Required:
  - Default build: exactly 1 beat (id 0) is buffered and stays stable.
  - SKID build: beats id 0 then id 3 are buffered.
  - On releasing `out_ready_i`, the beats are delivered in that order with none lost or duplicated.
- **Disabled channel.** `ch_en_i` = 0b111101 with channels 1 and 4 valid. Required: only channel 4 is served and `ch_ready_o[1]` stays 0. When `ch_en_i[1]` is set, channel 1 is served next.
- **Reset mid-burst.** Assert `rst_i` while `out_valid_o` = 1. Required: `out_valid_o` and `ch_ready_o` are 0 immediately. After reset is released, channel 0 has priority over channel 5 when both are requesting.
- **Pointer wrap.** With `ptr` = 5, channels 0 and 5 are both valid. Required: channel 0 is granted first, then channel 5.
